mcpu_core_tlbwalk_arb: RTL and testbench

MCPU_CORE_TLBWALK_ARB -- requirements
Module: mcpu_core_tlbwalk_arb

---
 rtl/mcpu_core_tlbwalk_arb.sv | 174 +++++++++++++++++
 tb/tb_mcpu_core_tlbwalk_arb.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_core_tlbwalk_arb.sv
// Shared two-level page-table walker for the ITLB and DTLB.
// Round-robin arbitration; one walk in flight on a single memory read port.
module mcpu_core_tlbwalk_arb (
    input  logic        clkrst_core_clk,
    input  logic        clkrst_core_rst,
    input  logic [19:0] pt_base,
    input  logic        itlb2pw_req,
    input  logic [19:0] itlb2pw_virtpage,
    output logic        pw2itlb_done,
    output logic [19:0] pw2itlb_physpage,
    output logic        pw2itlb_pagefault,
    input  logic        dtlb2pw_req,
    input  logic [19:0] dtlb2pw_virtpage,
    output logic        pw2dtlb_done,
    output logic [19:0] pw2dtlb_physpage,
    output logic        pw2dtlb_pagefault,
    input  logic        pipe_flush,
    output logic        pw2mem_valid,
    output logic [29:0] pw2mem_addr,
    input  logic        mem2pw_ready,
    input  logic        mem2pw_rvalid,
    input  logic [31:0] mem2pw_rdata
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] L1_REQ  = 3'd1;
    localparam logic [2:0] L1_WAIT = 3'd2;
    localparam logic [2:0] L2_REQ  = 3'd3;
    localparam logic [2:0] L2_WAIT = 3'd4;
    localparam logic [2:0] RESP    = 3'd5;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    logic [2:0]  state_q, state_d;
    logic        gnt_q, gnt_d;
    logic        last_q, last_d;
    logic        cancel_q, cancel_d;
    logic [19:0] ipage_q, ipage_d;
    logic        ifault_q, ifault_d;
    logic [19:0] dpage_q, dpage_d;
    logic        dfault_q, dfault_d;
    logic [19:0] vp_q, vp_d;
    logic [19:0] base_q, base_d;
    logic [19:0] tpage_q, tpage_d;

    logic        res_upd;
    logic [19:0] res_page;
    logic        res_fault;

    // PTE/PDE attribute bits other than present are not interpreted here.
    logic unused_rdata_bits;
    assign unused_rdata_bits = ^mem2pw_rdata[11:1];

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        cancel_d  = cancel_q;
        ipage_d   = ipage_q;
        ifault_d  = ifault_q;
        dpage_d   = dpage_q;
        dfault_d  = dfault_q;
        vp_d      = vp_q;
        base_d    = base_q;
        tpage_d   = tpage_q;
        res_upd   = 1'b0;
        res_page  = 20'h0;
        res_fault = 1'b0;

        if ((state_q != IDLE) && (gnt_q == GNT_I) && pipe_flush) begin
            cancel_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (itlb2pw_req || dtlb2pw_req) begin
                    gnt_d   = (itlb2pw_req && dtlb2pw_req) ? ~last_q : dtlb2pw_req;
                    vp_d    = (gnt_d == GNT_D) ? dtlb2pw_virtpage : itlb2pw_virtpage;
                    base_d  = pt_base;
                    state_d = L1_REQ;
                end
            end
            L1_REQ: begin
                if (mem2pw_ready) state_d = L1_WAIT;
            end
            L1_WAIT: begin
                if (mem2pw_rvalid) begin
                    if (!mem2pw_rdata[0]) begin
                        res_upd   = 1'b1;
                        res_fault = 1'b1;
                        state_d   = RESP;
                    end else begin
                        tpage_d = mem2pw_rdata[31:12];
                        state_d = L2_REQ;
                    end
                end
            end
            L2_REQ: begin
                if (mem2pw_ready) state_d = L2_WAIT;
            end
            L2_WAIT: begin
                if (mem2pw_rvalid) begin
                    res_upd   = 1'b1;
                    res_fault = ~mem2pw_rdata[0];
                    res_page  = mem2pw_rdata[0] ? mem2pw_rdata[31:12] : 20'h0;
                    state_d   = RESP;
                end
            end
            RESP: begin
                last_d   = gnt_q;
                cancel_d = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A cancelled ITLB walk leaves the ITLB result registers untouched.
        if (res_upd) begin
            if (gnt_q == GNT_D) begin
                dpage_d  = res_page;
                dfault_d = res_fault;
            end else if (!cancel_d) begin
                ipage_d  = res_page;
                ifault_d = res_fault;
            end
        end
    end

    always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
        if (clkrst_core_rst) begin
            state_q  <= IDLE;
            gnt_q    <= GNT_I;
            last_q   <= GNT_I;
            cancel_q <= 1'b0;
            ipage_q  <= 20'h0;
            ifault_q <= 1'b0;
            dpage_q  <= 20'h0;
            dfault_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            cancel_q <= cancel_d;
            ipage_q  <= ipage_d;
            ifault_q <= ifault_d;
            dpage_q  <= dpage_d;
            dfault_q <= dfault_d;
        end
    end

    always_ff @(posedge clkrst_core_clk) begin
        vp_q    <= vp_d;
        base_q  <= base_d;
        tpage_q <= tpage_d;
    end

    always_comb begin
        case (state_q)
            L1_REQ:  pw2mem_addr = {base_q, vp_q[19:10]};
            L2_REQ:  pw2mem_addr = {tpage_q, vp_q[9:0]};
            default: pw2mem_addr = 30'h0;
        endcase
    end

    assign pw2mem_valid      = (state_q == L1_REQ) || (state_q == L2_REQ);
    assign pw2itlb_done      = (state_q == RESP) && (gnt_q == GNT_I) && !cancel_q && !pipe_flush;
    assign pw2dtlb_done      = (state_q == RESP) && (gnt_q == GNT_D);
    assign pw2itlb_physpage  = ipage_q;
    assign pw2itlb_pagefault = ifault_q;
    assign pw2dtlb_physpage  = dpage_q;
    assign pw2dtlb_pagefault = dfault_q;

endmodule

// File: tb/tb_mcpu_core_tlbwalk_arb.sv
// Bench for mcpu_core_tlbwalk_arb: table of walks with a scoreboard queue,
// plus hand sequences for arbitration ties and reset mid-walk.
module tb_mcpu_core_tlbwalk_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] pt_base;
    logic        ireq, dreq, flush, ready, rvalid;
    logic [19:0] ivp, dvp;
    logic [31:0] rdata;
    logic        idone, ifault, ddone, dfault, mvalid;
    logic [19:0] iphys, dphys;
    logic [29:0] maddr;

    always #5 clk = ~clk;

    mcpu_core_tlbwalk_arb dut (
        .clkrst_core_clk   (clk),
        .clkrst_core_rst   (rst),
        .pt_base           (pt_base),
        .itlb2pw_req       (ireq),
        .itlb2pw_virtpage  (ivp),
        .pw2itlb_done      (idone),
        .pw2itlb_physpage  (iphys),
        .pw2itlb_pagefault (ifault),
        .dtlb2pw_req       (dreq),
        .dtlb2pw_virtpage  (dvp),
        .pw2dtlb_done      (ddone),
        .pw2dtlb_physpage  (dphys),
        .pw2dtlb_pagefault (dfault),
        .pipe_flush        (flush),
        .pw2mem_valid      (mvalid),
        .pw2mem_addr       (maddr),
        .mem2pw_ready      (ready),
        .mem2pw_rvalid     (rvalid),
        .mem2pw_rdata      (rdata)
    );

    typedef struct {
        bit          is_d;
        logic [19:0] base;
        logic [19:0] vp;
        logic [31:0] pde;
        logic [31:0] pte;
        int          stall;
        int          flush_k;
        int          l1;
        int          l2;
        int          done;
        int          lat;
        int          reads;
        int          phys;
        int          fault;
    } vec_t;

    typedef struct {
        int done;
        int lat;
        int reads;
        int phys;
        int fault;
    } exp_t;

    vec_t tbl[8];
    exp_t sbq[$];
    int   gq[$];
    int   checks = 0;
    int   errors = 0;

    logic [31:0] pde_g, pte_g;
    int          l1_g, l2_g, stall_g, nread;
    bit          acc_pend;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // One clock of the memory model: accept on valid (after optional stall), return data next cycle.
    task automatic cyc();
        @(negedge clk);
        ready  = 1'b0;
        rvalid = 1'b0;
        if (acc_pend) begin
            rvalid   = 1'b1;
            rdata    = (nread == 1) ? pde_g : pte_g;
            acc_pend = 1'b0;
        end else if (mvalid) begin
            chk("mem_addr", int'(maddr), (nread == 0) ? l1_g : l2_g);
            if (stall_g > 0) begin
                stall_g--;
            end else begin
                ready    = 1'b1;
                acc_pend = 1'b1;
                nread++;
            end
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1; ireq = 1'b0; dreq = 1'b0; flush = 1'b0;
        ready = 1'b0; rvalid = 1'b0; acc_pend = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic walk(input int i);
        vec_t v;
        exp_t e;
        bit   fin;
        v = tbl[i];
        pde_g = v.pde; pte_g = v.pte; l1_g = v.l1; l2_g = v.l2;
        stall_g = v.stall; nread = 0; acc_pend = 1'b0;
        e.done = v.done; e.lat = v.lat; e.reads = v.reads; e.phys = v.phys; e.fault = v.fault;
        sbq.push_back(e);
        @(negedge clk);
        pt_base = v.base;
        flush   = (v.flush_k == 0);
        if (v.is_d) begin dreq = 1'b1; dvp = v.vp; end
        else        begin ireq = 1'b1; ivp = v.vp; end
        fin = 1'b0;
        for (int k = 1; k <= 60 && !fin; k++) begin
            cyc();
            flush = (k == v.flush_k);
            if (idone || ddone || k == v.lat) begin
                e = sbq.pop_front();
                chk($sformatf("v%0d_latency", i), k, e.lat);
                chk($sformatf("v%0d_done", i), int'(v.is_d ? ddone : idone), e.done);
                chk($sformatf("v%0d_other_done", i), int'(v.is_d ? idone : ddone), 0);
                chk($sformatf("v%0d_reads", i), nread, e.reads);
                if (e.done != 0) begin
                    chk($sformatf("v%0d_phys", i), int'(v.is_d ? dphys : iphys), e.phys);
                    chk($sformatf("v%0d_fault", i), int'(v.is_d ? dfault : ifault), e.fault);
                end
                fin = 1'b1;
            end
        end
        ireq = 1'b0; dreq = 1'b0; flush = 1'b0;
        cyc();
        chk($sformatf("v%0d_pulse_i", i), int'(idone), 0);
        chk($sformatf("v%0d_pulse_d", i), int'(ddone), 0);
        chk($sformatf("v%0d_valid_idle", i), int'(mvalid), 0);
    endtask

    initial begin
        int n;
        rst = 1'b1; pt_base = '0; ivp = '0; dvp = '0; rdata = '0;
        ireq = 1'b0; dreq = 1'b0; flush = 1'b0; ready = 1'b0; rvalid = 1'b0;
        acc_pend = 1'b0; nread = 0;

        //        is_d base      vp        pde           pte           stl fk  l1           l2           dn lat rd phys      flt
        tbl[0] = '{1'b0, 20'h00010, 20'h00403, 32'h00020001, 32'h12345001, 0, -1, 'h04001,     'h08003,     1, 5, 2, 'h12345, 0};
        tbl[1] = '{1'b1, 20'h00010, 20'h00403, 32'h00000000, 32'h12345001, 0, -1, 'h04001,     'h08003,     1, 3, 1, 'h00000, 1};
        tbl[2] = '{1'b1, 20'hABCDE, 20'hFFFFF, 32'h55555001, 32'h99999000, 0, -1, 'h2AF37BFF,  'h155557FF,  1, 5, 2, 'h00000, 1};
        tbl[3] = '{1'b0, 20'h00010, 20'h00403, 32'h00020001, 32'h0ABCD003, 4, -1, 'h04001,     'h08003,     1, 9, 2, 'h0ABCD, 0};
        tbl[4] = '{1'b1, 20'h00001, 20'h00C05, 32'hFFFFF001, 32'h00001001, 0,  2, 'h00403,     'h3FFFFC05,  1, 5, 2, 'h00001, 0};
        tbl[5] = '{1'b0, 20'h00010, 20'h00403, 32'h00020001, 32'h12345001, 0,  4, 'h04001,     'h08003,     0, 5, 2, 'h00000, 0};
        tbl[6] = '{1'b1, 20'h00002, 20'h00001, 32'h00003001, 32'h7FFFF001, 0, -1, 'h00800,     'h00C01,     1, 5, 2, 'h7FFFF, 0};
        tbl[7] = '{1'b0, 20'h00010, 20'h00403, 32'h00020001, 32'h12345001, 0,  0, 'h04001,     'h08003,     1, 5, 2, 'h12345, 0};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_idone", int'(idone), 0);
        chk("rst_ddone", int'(ddone), 0);
        chk("rst_valid", int'(mvalid), 0);
        chk("rst_addr", int'(maddr), 0);
        chk("rst_iphys", int'(iphys), 0);
        chk("rst_dphys", int'(dphys), 0);
        chk("rst_ifault", int'(ifault), 0);
        chk("rst_dfault", int'(dfault), 0);

        for (int i = 0; i < 8; i++) walk(i);

        // Tie from reset: DTLB first, then strict alternation while both stay requesting.
        reset_dut();
        pde_g = 32'h00020001; pte_g = 32'h12345001; l1_g = 'h04001; l2_g = 'h08003;
        stall_g = 0; nread = 0;
        gq.push_back(1); gq.push_back(0); gq.push_back(1); gq.push_back(0);
        @(negedge clk);
        pt_base = 20'h00010; ivp = 20'h00403; dvp = 20'h00403; ireq = 1'b1; dreq = 1'b1;
        n = 0;
        for (int k = 1; k <= 80 && n < 4; k++) begin
            cyc();
            if (idone || ddone) begin
                chk("tie_both_done", int'(idone & ddone), 0);
                chk($sformatf("tie_order_%0d", n), int'(ddone), gq.pop_front());
                if (n == 0) chk("tie_first_latency", k, 5);
                n++;
                nread = 0;
            end
        end
        chk("tie_count", n, 4);
        ireq = 1'b0; dreq = 1'b0;
        cyc();
        cyc();

        // Reset while in L2_WAIT, then a stray read return in IDLE.
        pde_g = 32'h00020001; pte_g = 32'h12345001; l1_g = 'h04001; l2_g = 'h08003;
        stall_g = 0; nread = 0; acc_pend = 1'b0;
        @(negedge clk);
        pt_base = 20'h00010; ivp = 20'h00403; ireq = 1'b1;
        for (int k = 1; k <= 3; k++) cyc();
        @(negedge clk);
        rst = 1'b1; rvalid = 1'b0; ready = 1'b0; acc_pend = 1'b0; ireq = 1'b0;
        #1;
        chk("mrst_idone", int'(idone), 0);
        chk("mrst_valid", int'(mvalid), 0);
        chk("mrst_addr", int'(maddr), 0);
        chk("mrst_iphys", int'(iphys), 0);
        chk("mrst_dphys", int'(dphys), 0);
        chk("mrst_ifault", int'(ifault), 0);
        @(negedge clk);
        rst = 1'b0; rvalid = 1'b1; rdata = 32'h12345001;
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("late_rvalid_idone", int'(idone), 0);
            chk("late_rvalid_ddone", int'(ddone), 0);
            chk("late_rvalid_valid", int'(mvalid), 0);
        end
        chk("late_rvalid_iphys", int'(iphys), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
